// File: rtl/rob_unit.sv
`default_nettype none
//==============================================================================
// rob_unit - reorder buffer with dual-CDB writeback, operand lookup and in-order retire. Rev 1.0
//==============================================================================
module rob_unit #(
  parameter int         DEPTH       = 16,
  parameter logic [5:0] INVALID_TAG = 6'b010000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_dest,
  output logic        alloc_ready,
  output logic [5:0]  alloc_tag,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  input  logic        cdb2_valid,
  input  logic [5:0]  cdb2_tag,
  input  logic [31:0] cdb2_data,
  input  logic [5:0]  query_tag,
  output logic        query_ready,
  output logic [31:0] query_value,
  output logic        commit_valid,
  output logic [4:0]  commit_dest,
  output logic [5:0]  commit_tag,
  output logic [31:0] commit_data,
  output logic        empty,
  output logic        full
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam int                 c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

  logic               busy_q  [DEPTH];
  logic               done_q  [DEPTH];
  logic [4:0]         dest_q  [DEPTH];
  logic [31:0]        value_q [DEPTH];
  logic [c_ptr_w-1:0] head_q, head_d, tail_q, tail_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               commit_valid_q;
  logic [4:0]         commit_dest_q;
  logic [5:0]         commit_tag_q;
  logic [31:0]        commit_data_q;

  logic               alloc_fire, retire, cdb1_hit, cdb2_hit;
  logic [c_ptr_w-1:0] cdb1_idx, cdb2_idx, query_idx;

  // Tags at or above DEPTH (including INVALID_TAG) never address an entry.
  function automatic logic tag_ok(input logic [5:0] t);
    return (t != INVALID_TAG) && (t < 6'(DEPTH));
  endfunction

  assign cdb1_idx  = cdb_tag[c_ptr_w-1:0];
  assign cdb2_idx  = cdb2_tag[c_ptr_w-1:0];
  assign query_idx = query_tag[c_ptr_w-1:0];

  assign full        = (count_q == c_cnt_w'(DEPTH));
  assign empty       = (count_q == '0);
  assign alloc_ready = ~full & ~flush;
  assign alloc_tag   = 6'(tail_q);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign retire      = ~empty & done_q[head_q];
  assign cdb1_hit    = cdb_valid & tag_ok(cdb_tag) & busy_q[cdb1_idx];
  assign cdb2_hit    = cdb2_valid & tag_ok(cdb2_tag) & busy_q[cdb2_idx];

  assign commit_valid = commit_valid_q;
  assign commit_dest  = commit_dest_q;
  assign commit_tag   = commit_tag_q;
  assign commit_data  = commit_data_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (retire)     head_d = (head_q == c_last) ? '0 : head_q + 1'b1;
    if (alloc_fire) tail_d = (tail_q == c_last) ? '0 : tail_q + 1'b1;
    case ({alloc_fire, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Live CDB results bypass the stored value so a reservation station sees them this cycle.
  always_comb begin
    query_ready = 1'b0;
    query_value = '0;
    if (tag_ok(query_tag)) begin
      if (cdb1_hit && (cdb_tag == query_tag)) begin
        query_ready = 1'b1;
        query_value = cdb_data;
      end else if (cdb2_hit && (cdb2_tag == query_tag)) begin
        query_ready = 1'b1;
        query_value = cdb2_data;
      end else if (busy_q[query_idx] && done_q[query_idx]) begin
        query_ready = 1'b1;
        query_value = value_q[query_idx];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]  <= 1'b0;
        done_q[i]  <= 1'b0;
        dest_q[i]  <= '0;
        value_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_tag_q   <= '0;
      commit_data_q  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
    end else begin
      // Port 2 is written first so a port 1 write to the same tag overrides it.
      if (cdb2_hit) begin
        done_q[cdb2_idx]  <= 1'b1;
        value_q[cdb2_idx] <= cdb2_data;
      end
      if (cdb1_hit) begin
        done_q[cdb1_idx]  <= 1'b1;
        value_q[cdb1_idx] <= cdb_data;
      end
      if (alloc_fire) begin
        busy_q[tail_q]  <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        dest_q[tail_q]  <= alloc_dest;
        value_q[tail_q] <= '0;
      end
      if (retire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        commit_dest_q  <= dest_q[head_q];
        commit_tag_q   <= 6'(head_q);
        commit_data_q  <= value_q[head_q];
      end
      commit_valid_q <= retire;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/rob_unit.md
ROB_UNIT -- requirements
Module: rob_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of reorder-buffer entries; tags 0..15 are valid.
REQ-002 SHALL have parameter INVALID_TAG, default 6'b010000, meaning the "no producer / operand ready" tag.
REQ-003 SHALL have port clock  input  1  clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous clear of all entries.
REQ-006 SHALL have port alloc_valid  input  1  issue requests one entry.
REQ-007 SHALL have port alloc_dest  input  5  architectural destination register.
REQ-008 SHALL have port alloc_ready  output  1  entry available (combinational).
REQ-009 SHALL have port alloc_tag  output  6  tag granted on acceptance, {2'b00,tail}.
REQ-010 SHALL have ports cdb_valid, cdb_tag, cdb_data  input  1/6/32  CDB port 1.
REQ-011 SHALL have ports cdb2_valid, cdb2_tag, cdb2_data  input  1/6/32  CDB port 2.
REQ-012 SHALL have port query_tag  input  6  operand lookup tag from a reservation station.
REQ-013 SHALL have ports query_ready, query_value  output  1/32  lookup result (combinational).
REQ-014 SHALL have ports commit_valid, commit_dest, commit_tag, commit_data  output  1/5/6/32  registered retire stream.
REQ-015 SHALL have ports empty, full  output  1/1  count==0, count==DEPTH.

Function
REQ-016 SHALL hold per entry: busy, done, dest[4:0], value[31:0]; head/tail 4-bit pointers; count 0..16.
REQ-017 SHALL drive alloc_ready = ~full & ~flush; a commit in the same cycle does not free space for allocation.
REQ-018 SHALL, on alloc_valid & alloc_ready at a posedge, set entry[tail] busy=1, done=0, dest=alloc_dest, value=0, and advance tail modulo 16.
REQ-019 SHALL, for each CDB port with valid=1, tag<16 and entry[tag].busy=1, set done=1 and value=data at the posedge.
REQ-020 SHALL ignore CDB writes with tag>=16 or to non-busy entries.
REQ-021 SHALL give port 1 priority when both ports write the same tag in one cycle.
REQ-022 SHALL drive query_ready=1, query_value=entry value when query_tag<16, busy=1 and done=1.
REQ-023 SHALL forward a same-cycle CDB write matching query_tag to query_ready=1 and query_value=CDB data, with port 1 priority over port 2 and both over stored value.
REQ-024 SHALL otherwise drive query_ready=0 and query_value=0, including when query_tag>=16.
REQ-025 SHALL, at each posedge with count>0 and entry[head].done=1 as registered before the edge, retire head: busy=0, head+1 modulo 16, and set commit_valid=1, commit_dest, commit_tag={2'b00,head}, commit_data.
REQ-026 SHALL set commit_valid=0 in any cycle without a retire; commit_dest/tag/data hold their last values.
REQ-027 SHALL retire at most one entry per cycle, strictly in allocation order; a done younger entry waits behind a not-done head.
REQ-028 SHALL have a minimum latency of CDB write at edge N -> commit_valid=1 after edge N+1.
REQ-029 SHALL update count by +1 on alloc only, -1 on retire only, and leave it unchanged on both.
REQ-030 SHALL, on flush at a posedge, clear all busy/done bits, head=tail=count=0, commit_valid=0, and ignore alloc and CDB that cycle.

Reset
REQ-031 SHALL, while reset=1 and asynchronously, clear all entries (busy, done, dest, value =0), head=tail=count=0, and commit_valid/dest/tag/data=0.
REQ-032 SHALL drive the following after reset: alloc_ready=1, alloc_tag=0, empty=1, full=0, query_ready=0.
REQ-033 SHALL cleanly abandon in-flight entries when reset is asserted mid-operation; no commit appears after release.

Verification
REQ-034 SHALL be verified by this scenario: reset; alloc dest=5 -> tag 0; CDB1 tag0 data 0x1234 -> next cycle commit_valid=1, dest=5, tag=0, data=0x1234, then empty=1.
REQ-035 SHALL be verified by this scenario: alloc tags 0,1; CDB writes tag1=7 then tag0=9 -> commits tag0 (9) then tag1 (7) on consecutive cycles.
REQ-036 SHALL be verified by this scenario: 16 allocs without CDB -> full=1, alloc_ready=0, 17th alloc ignored; complete tag0 -> retire, then alloc returns tag 0 (wrap).
REQ-037 SHALL be verified by this scenario: both CDB ports write tag 3 (0xA / 0xB) in one cycle -> stored value 0xA; query_tag=3 that cycle -> query_ready=1, value 0xA.
REQ-038 SHALL be verified by this scenario: query_tag=16 -> query_ready=0, value 0; CDB write to free tag 8 -> no state change, no commit.
REQ-039 SHALL be verified by this scenario: 4 entries live, 2 done, then flush -> empty=1, commit_valid=0, next alloc tag 0.
